uart_me_cmd_ctrl: RTL and testbench
===================================

Name: uart_me_cmd_ctrl

Overview:
Host-side (ME) controller for the UART calculator link. It serialises a 16-bit operand/command word into a 3-byte frame for the SE: low byte, high byte, then the terminator 0x0D. Optionally, it then collects the SE's 2-byte result (low byte first) and presents it as a 16-bit word. It sits between the uart_basic transmit/receive handshake and the ME-side user logic (switches, buttons, display).

Parameters:
INTER_BYTE_DELAY, 1000000, idle clock cycles between end of one TX byte and register of next
WAIT_FOR_REGISTER_DELAY, 100, cycles tx_data is held stable before the tx_start pulse
RESP_TIMEOUT, 50000000, max cycles waited for each response byte before abort

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous, active-low reset
send  in  1  request pulse; frame transmission starts when sampled high in IDLE
cmd_data  in  16  word to send; captured on the accepted send cycle
expect_resp  in  1  captured with send; 1 = wait for 2-byte result after frame
tx_data  out  8  byte to uart_basic
tx_start  out  1  one-cycle transmit strobe to uart_basic
tx_busy  in  1  uart_basic transmitter busy
rx_data  in  8  received byte from uart_basic
rx_ready  in  1  one-cycle strobe, rx_data valid
busy  out  1  high in every state except IDLE
result  out  16  last complete response, {hi,lo}
result_valid  out  1  one-cycle pulse when result updates
timeout  out  1  one-cycle pulse on response abort
state  out  4  state encoding, for LEDs

Behaviour:
- Reset (async assert, sync-release use): state=IDLE. tx_data=0, tx_start=0, busy=0, result=0, result_valid=0, timeout=0, all counters=0. Reset mid-frame aborts with no further tx_start.
- State encoding: IDLE=0, LOAD=1, START=2, WAIT_HI=3, WAIT_LO=4, GAP=5, RX_LO=6, RX_HI=7, DONE=8.
- IDLE: on send=1, latch cmd_data and expect_resp, set byte index k=0, go to LOAD. send in any other state is ignored (no queueing).
- LOAD: tx_data = byte k (k0=cmd[7:0], k1=cmd[15:8], k2=8'h0D). Count WAIT_FOR_REGISTER_DELAY cycles, then go to START.
- START: tx_start=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: go to WAIT_LO on tx_busy=1. If tx_busy is not seen within 16 cycles, go to WAIT_LO anyway.
- WAIT_LO: on tx_busy=0:
  - k<2: go to GAP.
  - k=2: go to RX_LO if expect_resp, else DONE.
- GAP: count INTER_BYTE_DELAY cycles, then k=k+1 and go to LOAD.
- tx_data is held constant from LOAD entry until the next LOAD.
- RX_LO: on rx_ready, store lo=rx_data and go to RX_HI.
- RX_HI: on rx_ready, result={rx_data,lo}, result_valid=1 for one cycle, go to DONE.
- RX timeout:
  - The timeout counter clears on entry to RX_LO and RX_HI.
  - If RESP_TIMEOUT cycles pass with no rx_ready: timeout=1 for one cycle, result unchanged, go to DONE.
  - A byte arriving on the same cycle the count expires is accepted; the timeout does not fire.
- rx_ready outside RX_LO/RX_HI is discarded; it does not disturb the TX sequence or result.
- DONE: one cycle, then IDLE. busy drops in the cycle IDLE is re-entered. A new send is accepted on the first IDLE cycle.
- Per byte, minimum latency from LOAD entry to tx_start = WAIT_FOR_REGISTER_DELAY cycles.
- No gap after byte 2. result holds its value until the next successful response or reset.

Test Plan:
(Sim parameters: INTER_BYTE_DELAY=20, WAIT_FOR_REGISTER_DELAY=4, RESP_TIMEOUT=200; uart_basic TX modelled with tx_busy high for 30 cycles starting 1 cycle after tx_start.)
1. Reset with CPU_RESETN=0 mid-cycle -> all outputs 0 immediately; state=0.
2. send=1, cmd_data=16'h1234, expect_resp=0 -> exactly 3 tx_start pulses with tx_data 0x34, 0x12, 0x0D. Each pulse follows ≥4 stable cycles, with ≥20 idle cycles between busy-fall and next LOAD end. busy returns to 0; result_valid never pulses.
3. send with cmd_data=16'h00FF, expect_resp=1, then rx bytes 0xCD, 0xAB after frame -> result=16'hABCD, one result_valid pulse, busy=0 after.
4. expect_resp=1, send only 0x55 then nothing -> timeout pulse 200 cycles after the 0x55 byte, result keeps its prior value (16'hABCD), state returns to 0.
5. Second send pulse during byte 1 plus stray rx_ready=1 (rx_data=0x77) during GAP -> frame unchanged, no extra tx_start, result unaffected.
6. CPU_RESETN pulsed low during GAP after byte 0 -> no further tx_start; next send after release transmits a full fresh 3-byte frame.

Source files
------------

// File: rtl/uart_me_cmd_ctrl.sv
// rtl/uart_me_cmd_ctrl.sv - ME-side UART command framer: sends {lo, hi, 0x0D}, optionally collects a 2-byte result
`timescale 1ns/1ps
module uart_me_cmd_ctrl #(
   parameter int INTER_BYTE_DELAY        = 1000000,
   parameter int WAIT_FOR_REGISTER_DELAY = 100,
   parameter int RESP_TIMEOUT            = 50000000
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        send,
   input  logic [15:0] cmd_data,
   input  logic        expect_resp,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        busy,
   output logic [15:0] result,
   output logic        result_valid,
   output logic        timeout,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_START   = 4'd2,
      ST_WAIT_HI = 4'd3,
      ST_WAIT_LO = 4'd4,
      ST_GAP     = 4'd5,
      ST_RX_LO   = 4'd6,
      ST_RX_HI   = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   localparam logic [31:0] LOAD_LAST = 32'(WAIT_FOR_REGISTER_DELAY - 1);
   localparam logic [31:0] GAP_LAST  = 32'(INTER_BYTE_DELAY - 1);
   localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
   localparam logic [31:0] HI_LAST   = 32'd15;
   localparam logic [7:0]  TERM_BYTE = 8'h0D;

   state_t      state_r;
   state_t      state_next;
   logic [31:0] cnt;
   logic [1:0]  k;
   logic [7:0]  cmd_hi;
   logic        exp_r;
   logic [7:0]  lo_r;

   logic load_done;
   logic gap_done;
   logic rx_expired;
   logic hi_expired;

   assign load_done  = (cnt == LOAD_LAST);
   assign gap_done   = (cnt == GAP_LAST);
   assign rx_expired = (cnt == RESP_LAST);
   assign hi_expired = (cnt == HI_LAST);

   assign state    = state_r;
   assign tx_start = (state_r == ST_START);
   assign busy     = (state_r != ST_IDLE);

   always_comb begin
      state_next = state_r;
      case (state_r)
         ST_IDLE:    if (send) state_next = ST_LOAD;
         ST_LOAD:    if (load_done) state_next = ST_START;
         ST_START:   state_next = ST_WAIT_HI;
         ST_WAIT_HI: if (tx_busy || hi_expired) state_next = ST_WAIT_LO;
         ST_WAIT_LO: begin
            if (!tx_busy) begin
               if (k != 2'd2)  state_next = ST_GAP;
               else if (exp_r) state_next = ST_RX_LO;
               else            state_next = ST_DONE;
            end
         end
         ST_GAP:     if (gap_done) state_next = ST_LOAD;
         // a byte arriving on the expiry cycle wins over the timeout
         ST_RX_LO: begin
            if (rx_ready)        state_next = ST_RX_HI;
            else if (rx_expired) state_next = ST_DONE;
         end
         ST_RX_HI:   if (rx_ready || rx_expired) state_next = ST_DONE;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_r      <= ST_IDLE;
         cnt          <= '0;
         k            <= '0;
         cmd_hi       <= '0;
         exp_r        <= 1'b0;
         lo_r         <= '0;
         tx_data      <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state_r      <= state_next;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
         // one shared counter; every timed state starts from zero on entry
         if (state_next != state_r) cnt <= '0;
         else if (state_r != ST_IDLE) cnt <= cnt + 32'd1;
         case (state_r)
            ST_IDLE: begin
               if (send) begin
                  cmd_hi  <= cmd_data[15:8];
                  exp_r   <= expect_resp;
                  k       <= 2'd0;
                  tx_data <= cmd_data[7:0];
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  k       <= k + 2'd1;
                  tx_data <= (k == 2'd0) ? cmd_hi : TERM_BYTE;
               end
            end
            ST_RX_LO: begin
               if (rx_ready)        lo_r    <= rx_data;
               else if (rx_expired) timeout <= 1'b1;
            end
            ST_RX_HI: begin
               if (rx_ready) begin
                  result       <= {rx_data, lo_r};
                  result_valid <= 1'b1;
               end else if (rx_expired) begin
                  timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_me_cmd_ctrl.sv
// tb/tb_uart_me_cmd_ctrl.sv - randomized self-checking bench for uart_me_cmd_ctrl
`timescale 1ns/1ps
module tb_uart_me_cmd_ctrl;

   localparam int D = 20;
   localparam int W = 4;
   localparam int T = 200;

   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic        send = 1'b0;
   logic [15:0] cmd_data = '0;
   logic        expect_resp = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready = 1'b0;
   logic        busy;
   logic [15:0] result;
   logic        result_valid;
   logic        timeout;
   logic [3:0]  state;

   uart_me_cmd_ctrl #(
      .INTER_BYTE_DELAY(D), .WAIT_FOR_REGISTER_DELAY(W), .RESP_TIMEOUT(T)
   ) dut (
      .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .send(send), .cmd_data(cmd_data),
      .expect_resp(expect_resp), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy), .result(result),
      .result_valid(result_valid), .timeout(timeout), .state(state)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stable = 0;
   int busy_left = 0;
   int rv_count = 0;
   int to_count = 0;
   int to_cyc = 0;
   logic [7:0]  prev_data = '0;
   logic [15:0] rv_result = '0;
   int          start_q[$];
   int          fall_q[$];
   int          stab_q[$];
   logic [7:0]  byte_q[$];

   // uart_basic transmitter model plus event recorder
   always @(negedge CLK100MHZ) begin
      cyc++;
      if (tx_data === prev_data) stable++;
      else stable = 0;
      prev_data = tx_data;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            tx_busy = 1'b0;
            fall_q.push_back(cyc);
         end
      end
      if (tx_start === 1'b1) begin
         start_q.push_back(cyc);
         byte_q.push_back(tx_data);
         stab_q.push_back(stable);
         tx_busy   = 1'b1;
         busy_left = 30;
      end
      if (result_valid === 1'b1) begin
         rv_count++;
         rv_result = result;
      end
      if (timeout === 1'b1) begin
         to_count++;
         to_cyc = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK100MHZ);
         #1;
      end
   endtask

   task automatic clear_q();
      start_q.delete();
      fall_q.delete();
      stab_q.delete();
      byte_q.delete();
   endtask

   task automatic send_cmd(input logic [15:0] c, input logic e);
      send = 1'b1;
      cmd_data = c;
      expect_resp = e;
      tick(1);
      send = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, output int c);
      rx_data = b;
      rx_ready = 1'b1;
      c = cyc;
      tick(1);
      rx_ready = 1'b0;
   endtask

   task automatic wait_tx(input int ns, input int nf, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (start_q.size() >= ns && fall_q.size() >= nf) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      CPU_RESETN = 1'b0;
      tick(3);
      CPU_RESETN = 1'b1;
      tick(2);
      send_cmd(16'hBEEF, 1'b1);
      tick(3);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b expected 1", busy); end
      #2 CPU_RESETN = 1'b0;
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
      checks++; if (result_valid !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL reset_pulses: got rv=%b to=%b expected 0 0", result_valid, timeout);
      end
      tick(2);
      CPU_RESETN = 1'b1;
      tick(2);
      clear_q();
   endtask

   task automatic test_frame();
      logic [15:0] cmds [4];
      logic [7:0]  exp_b [3];
      bit          ok;
      int          rv0;
      cmds[0] = 16'h1234;
      for (int j = 1; j < 4; j++) cmds[j] = 16'($urandom);
      for (int j = 0; j < 4; j++) begin
         clear_q();
         rv0 = rv_count;
         exp_b[0] = cmds[j][7:0];
         exp_b[1] = cmds[j][15:8];
         exp_b[2] = 8'h0D;
         send_cmd(cmds[j], 1'b0);
         wait_tx(3, 3, ok);
         checks++; if (!ok) begin errors++; $display("FAIL frame_wait: got %0d starts expected 3", start_q.size()); end
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("FAIL frame_idle: got busy=%b expected 0", busy); end
         tick(40);
         checks++; if (start_q.size() != 3) begin errors++; $display("FAIL frame_count: got %0d expected 3", start_q.size()); end
         for (int i = 0; i < 3 && i < byte_q.size(); i++) begin
            checks++; if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL frame_byte%0d: got %h expected %h", i, byte_q[i], exp_b[i]); end
            checks++; if (stab_q[i] < W) begin errors++; $display("FAIL frame_stable%0d: got %0d expected >=%0d", i, stab_q[i], W); end
         end
         for (int i = 0; i < 2 && i + 1 < start_q.size() && i < fall_q.size(); i++) begin
            checks++; if (start_q[i+1] - fall_q[i] < D + W) begin
               errors++; $display("FAIL frame_gap%0d: got %0d expected >=%0d", i, start_q[i+1] - fall_q[i], D + W);
            end
         end
         checks++; if (rv_count != rv0) begin errors++; $display("FAIL frame_no_rv: got %0d pulses expected 0", rv_count - rv0); end
      end
   endtask

   task automatic test_response();
      logic [15:0] c;
      logic [7:0]  lo, hi;
      bit          ok;
      int          rv0, to0, cdum;
      for (int j = 0; j < 4; j++) begin
         if (j == 3) begin c = 16'h00FF; lo = 8'hCD; hi = 8'hAB; end
         else begin c = 16'($urandom); lo = 8'($urandom); hi = 8'($urandom); end
         clear_q();
         rv0 = rv_count;
         to0 = to_count;
         send_cmd(c, 1'b1);
         wait_tx(3, 3, ok);
         checks++; if (!ok) begin errors++; $display("FAIL resp_frame_wait: got %0d starts expected 3", start_q.size()); end
         tick($urandom_range(2, 20));
         send_rx(lo, cdum);
         tick($urandom_range(0, 30));
         send_rx(hi, cdum);
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("FAIL resp_idle: got busy=%b expected 0", busy); end
         checks++; if (rv_count - rv0 != 1) begin errors++; $display("FAIL resp_rv_count: got %0d expected 1", rv_count - rv0); end
         checks++; if (rv_result !== {hi, lo}) begin errors++; $display("FAIL resp_rv_value: got %h expected %h", rv_result, {hi, lo}); end
         checks++; if (result !== {hi, lo}) begin errors++; $display("FAIL resp_result: got %h expected %h", result, {hi, lo}); end
         checks++; if (to_count != to0) begin errors++; $display("FAIL resp_no_timeout: got %0d expected 0", to_count - to0); end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int rv0, to0, c55;
      clear_q();
      rv0 = rv_count;
      to0 = to_count;
      send_cmd(16'($urandom), 1'b1);
      wait_tx(3, 3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_frame_wait: got %0d starts expected 3", start_q.size()); end
      tick(2);
      send_rx(8'h55, c55);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (to_count > to0) begin ok = 1'b1; break; end
         tick(1);
      end
      checks++; if (!ok) begin errors++; $display("FAIL to_pulse: got none expected one"); end
      checks++; if (to_cyc - c55 < T || to_cyc - c55 > T + 1) begin
         errors++; $display("FAIL to_latency: got %0d expected %0d..%0d", to_cyc - c55, T, T + 1);
      end
      tick(3);
      checks++; if (to_count - to0 != 1) begin errors++; $display("FAIL to_count: got %0d expected 1", to_count - to0); end
      checks++; if (result !== 16'hABCD) begin errors++; $display("FAIL to_result: got %h expected abcd", result); end
      checks++; if (rv_count != rv0) begin errors++; $display("FAIL to_no_rv: got %0d expected 0", rv_count - rv0); end
      checks++; if (state !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL to_idle: got state=%0d busy=%b expected 0 0", state, busy); end
   endtask

   task automatic test_ignored_inputs();
      logic [15:0] a, b;
      bit          ok;
      int          rv0, to0, cdum;
      a = 16'($urandom);
      b = ~a;
      clear_q();
      rv0 = rv_count;
      to0 = to_count;
      send_cmd(a, 1'b0);
      wait_tx(1, 1, ok);
      tick(5);
      send_rx(8'h77, cdum);
      wait_tx(2, 1, ok);
      tick(3);
      send_cmd(b, 1'b1);
      wait_tx(3, 3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_frame_wait: got %0d starts expected 3", start_q.size()); end
      tick(300);
      checks++; if (start_q.size() != 3) begin errors++; $display("FAIL ign_count: got %0d expected 3", start_q.size()); end
      checks++; if (byte_q.size() > 1 && byte_q[1] !== a[15:8]) begin errors++; $display("FAIL ign_byte1: got %h expected %h", byte_q[1], a[15:8]); end
      checks++; if (result !== 16'hABCD) begin errors++; $display("FAIL ign_result: got %h expected abcd", result); end
      checks++; if (rv_count != rv0 || to_count != to0) begin
         errors++; $display("FAIL ign_pulses: got rv=%0d to=%0d expected 0 0", rv_count - rv0, to_count - to0);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b expected 0", busy); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] c;
      bit          ok;
      c = 16'($urandom);
      clear_q();
      send_cmd(16'($urandom), 1'b0);
      wait_tx(1, 1, ok);
      tick(5);
      CPU_RESETN = 1'b0;
      tick(2);
      CPU_RESETN = 1'b1;
      tick(100);
      checks++; if (start_q.size() != 1) begin errors++; $display("FAIL rst_abort: got %0d starts expected 1", start_q.size()); end
      checks++; if (state !== 4'd0 || result !== 16'h0) begin
         errors++; $display("FAIL rst_state: got state=%0d result=%h expected 0 0000", state, result);
      end
      clear_q();
      send_cmd(c, 1'b0);
      wait_tx(3, 3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_fresh_wait: got %0d starts expected 3", start_q.size()); end
      wait_idle(ok);
      tick(40);
      checks++; if (start_q.size() != 3) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 3", start_q.size()); end
      checks++; if (byte_q.size() >= 3 && (byte_q[0] !== c[7:0] || byte_q[1] !== c[15:8] || byte_q[2] !== 8'h0D)) begin
         errors++; $display("FAIL rst_fresh_bytes: got %h %h %h expected %h %h 0d", byte_q[0], byte_q[1], byte_q[2], c[7:0], c[15:8]);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_response();
      test_timeout();
      test_ignored_inputs();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
